// File: rtl/com.sv
// com: shared UART definitions used by both the transmitter and the receiver.
package com;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t;

    // Rounded clock-per-bit divisor, so TX and RX agree on the bit period.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// synchronizer: N-flop single-bit synchroniser with a configurable reset value.
module synchronizer #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!rst_) ff <= {STAGES{RST_VAL}};
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver delivering bytes on a valid/ready stream.
module uart_rx
    import com::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV  = baud_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    if (DIV < 4) begin : g_div_chk
        $error("uart_rx: baud divisor must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
        $error("uart_rx: DATA_BITS must be 5..8");
    end

    uart_rx_state_t       state;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] sh;
    logic                 bit_end;

    synchronizer #(.STAGES(2), .RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_ (rst_),
        .d    (rx),
        .q    (rx_s)
    );

    assign bit_end = cnt == CW'(DIV - 1);

    always_ff @(posedge clk) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
        if (!rst_) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            data    <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= state != IDLE;
            if (valid && ready) valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    cnt <= cnt + 1'b1;
                    if (bit_end) begin
                        cnt     <= '0;
                        sh      <= {rx_s, sh[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt + 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            // A full holding register that is not being drained keeps its byte.
                            if (!valid || ready) begin
                                data  <= sh;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frame tests against a timing/scoreboard model.
module tb_uart_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int LAT    = 3 + HALF + 9 * DIV;

    typedef struct {
        int c;
        int d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    ev_t dq[$];
    int  fe_q[$];
    int  ov_q[$];
    int  vhi = 0;
    int  unstable = 0;
    logic       pv = 1'b0;
    logic       pacc = 1'b0;
    logic [7:0] pd = 8'h00;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event monitor: a delivery is a valid that is new or follows an accepted byte.
    always @(negedge clk) begin
        if (valid && (!pv || pacc)) dq.push_back('{cyc, int'(data)});
        if (frame_err) fe_q.push_back(cyc);
        if (overrun) ov_q.push_back(cyc);
        if (valid) vhi++;
        if (pv && !pacc && valid && data != pd) unstable++;
        pv   = valid;
        pacc = valid && ready;
        pd   = data;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_lat(input string tag, input int got_c, input int exp_c);
        int d;
        d = got_c - exp_c;
        check(tag, (d >= -1 && d <= 1) ? 0 : d, 0);
    endtask

    function automatic int dq_d(input int i);
        return (dq.size() > i) ? dq[i].d : -1;
    endfunction

    function automatic int dq_c(input int i);
        return (dq.size() > i) ? dq[i].c : -1;
    endfunction

    task automatic clear();
        dq.delete();
        fe_q.delete();
        ov_q.delete();
        vhi      = 0;
        unstable = 0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Caller must be at a falling clock edge; frames chain with no gap.
    task automatic send(input logic [7:0] b, input logic stop_bit, output int t0);
        rx = 1'b0;
        t0 = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t0, t1;
        int rb[4];
        int rt[4];
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        rst_ = 1'b1;
        idle(5);

        clear();
        fork
            send(8'h55, 1'b1, t0);
            begin
                repeat (2000) @(negedge clk);
                check("busy_mid", busy, 1);
            end
        join
        idle(10);
        check("b55_count", dq.size(), 1);
        check("b55_data", dq_d(0), 8'h55);
        check_lat("b55_lat", dq_c(0), t0 + LAT);
        check("b55_vwidth", vhi, 1);
        check("b55_ferr", fe_q.size(), 0);
        check("b55_ovr", ov_q.size(), 0);
        check("b55_busy_idle", busy, 0);

        clear();
        send(8'hA5, 1'b1, t0);
        send(8'h3C, 1'b1, t1);
        idle(10);
        check("b2b_count", dq.size(), 2);
        check("b2b_d0", dq_d(0), 8'hA5);
        check("b2b_d1", dq_d(1), 8'h3C);
        check_lat("b2b_lat", dq_c(0), t0 + LAT);
        check("b2b_gap", dq_c(1) - dq_c(0), 10 * DIV);

        ready = 1'b0;
        clear();
        send(8'h11, 1'b1, t0);
        send(8'h22, 1'b1, t1);
        idle(10);
        check("ovr_data", data, 8'h11);
        check("ovr_valid", valid, 1);
        check("ovr_count", ov_q.size(), 1);
        check_lat("ovr_lat", (ov_q.size() > 0) ? ov_q[0] : -1, t1 + LAT);
        check("ovr_deliv", dq.size(), 1);
        check("ovr_stable", unstable, 0);

        clear();
        fork
            send(8'hC3, 1'b1, t0);
            begin
                repeat (7 * DIV + 100) @(negedge clk);
                check("pre_rst_busy", busy, 1);
                rst_ = 1'b0;
                @(negedge clk);
                rst_ = 1'b1;
                check("mid_rst_data", data, 0);
                check("mid_rst_valid", valid, 0);
                check("mid_rst_busy", busy, 0);
                check("mid_rst_ferr", frame_err, 0);
                check("mid_rst_ovr", overrun, 0);
            end
        join
        idle(10);
        check("mid_rst_nodeliv", dq.size(), 0);
        ready = 1'b1;
        clear();
        send(8'h5A, 1'b1, t0);
        idle(10);
        check("post_rst_count", dq.size(), 1);
        check("post_rst_data", dq_d(0), 8'h5A);
        check_lat("post_rst_lat", dq_c(0), t0 + LAT);

        clear();
        send(8'h7E, 1'b0, t0);
        repeat (3 * DIV) @(negedge clk);
        check("brk_busy", busy, 1);
        idle(2 * DIV);
        check("brk_ferr", fe_q.size(), 1);
        check_lat("brk_lat", (fe_q.size() > 0) ? fe_q[0] : -1, t0 + LAT);
        check("brk_deliv", dq.size(), 0);
        check("brk_valid", vhi, 0);
        check("brk_busy_end", busy, 0);

        clear();
        rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(2 * DIV);
        check("glitch_deliv", dq.size(), 0);
        check("glitch_ferr", fe_q.size(), 0);
        check("glitch_ovr", ov_q.size(), 0);
        check("glitch_busy", busy, 0);

        clear();
        for (int i = 0; i < 4; i++) begin
            rb[i] = int'($urandom_range(0, 255));
            send(8'(rb[i]), 1'b1, t0);
            rt[i] = t0;
            idle(int'($urandom_range(0, 40)));
        end
        idle(10);
        check("rnd_count", dq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rnd_d%0d", i), dq_d(i), rb[i]);
            check_lat($sformatf("rnd_lat%0d", i), dq_c(i), rt[i] + LAT);
        end
        check("rnd_ferr", fe_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
